// File: rtl/tfe_rxm_rd_sys.sv
// Receive read-out stage: pops one descriptor per packet and streams its bytes out of the 4 KB receive RAM.
// Latency: f_rdEn at t, descriptor latched at t+1, first RAM read at t+2, first byte (sop) on out_en at t+3.
// Backpressure: out_rdy stalls the output. A 2-entry skid buffer absorbs the 1-cycle RAM latency, and a RAM
//               read is only issued when a slot is guaranteed, so stalling never loses or duplicates a byte.
// Ports: sysclk/rst (sync, active high); f_* descriptor FIFO read side; ramRd* RAM read side plus the
//        released-block index; out_* byte stream with sop/eop, PT and length; rd_pkt_cnt/rd_err_cnt counters.
module tfe_rxm_rd_sys #(
    parameter bit STRIP_FCS = 1'b1
) (
    input  logic        sysclk,
    input  logic        rst,
    input  logic        f_empty,
    output logic        f_rdEn,
    input  logic [31:0] f_rdDa,
    output logic [11:0] ramRdAddr,
    output logic        ramRdEn,
    input  logic [7:0]  ramRdDa,
    output logic [4:0]  ramRdBlk,
    output logic        out_en,
    output logic [7:0]  out_da,
    output logic        out_sop,
    output logic        out_eop,
    output logic [7:0]  out_pt,
    output logic [10:0] out_len,
    input  logic        out_rdy,
    output logic [15:0] rd_pkt_cnt,
    output logic [15:0] rd_err_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_POP, S_LATCH, S_READ, S_DRAIN, S_RELEASE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  pt_q, pt_d;
    logic [4:0]  ieb_q, ieb_d;
    logic [10:0] len_q, len_d;
    logic        drop_q, drop_d;
    logic [11:0] ptr_q, ptr_d;
    logic [10:0] rd_cnt_q, rd_cnt_d;     // RAM reads issued for this packet
    logic [10:0] out_idx_q, out_idx_d;   // bytes accepted downstream for this packet
    logic        rd_pend_q, rd_pend_d;   // a read was issued last cycle: ramRdDa is valid now
    logic [1:0]  cnt_q, cnt_d;           // skid buffer occupancy
    logic [7:0]  buf0_q, buf0_d, buf1_q, buf1_d;
    logic [4:0]  blk_q, blk_d;
    logic [15:0] pkt_q, pkt_d;
    logic [15:0] err_q, err_d;

    // Descriptor decode, only meaningful in LATCH
    logic [10:0] d_dl, d_len;
    logic [4:0]  d_isb, d_ieb;
    logic [11:0] d_end_addr;
    logic        d_drop, d_bad;
    logic        unused_desc_bits;

    assign d_dl       = f_rdDa[10:0];
    assign d_isb      = f_rdDa[15:11];
    assign d_ieb      = f_rdDa[20:16];
    assign d_len      = STRIP_FCS ? (d_dl - 11'd4) : d_dl;
    assign d_drop     = (d_dl == 11'd0) || (STRIP_FCS && (d_dl < 11'd5));
    // Address of the last byte modulo 4 KB; its block index is what the writer should have reported.
    assign d_end_addr = {d_isb, 7'h00} + {1'b0, d_dl} - 12'd1;
    assign d_bad      = (d_end_addr[11:7] != d_ieb);
    assign unused_desc_bits = ^f_rdDa[23:21];

    logic       acc, pop_buf, push, last_byte;
    logic [1:0] cnt_after_pop;
    logic [2:0] occ;

    always_comb begin
        state_d   = state_q;
        pt_d      = pt_q;
        ieb_d     = ieb_q;
        len_d     = len_q;
        drop_d    = drop_q;
        ptr_d     = ptr_q;
        rd_cnt_d  = rd_cnt_q;
        out_idx_d = out_idx_q;
        cnt_d     = cnt_q;
        buf0_d    = buf0_q;
        buf1_d    = buf1_q;
        blk_d     = blk_q;
        pkt_d     = pkt_q;
        err_d     = err_q;
        f_rdEn    = 1'b0;

        // Head byte comes from the skid buffer, or straight from the RAM when the buffer is empty.
        out_en    = (cnt_q != 2'd0) || rd_pend_q;
        out_da    = (cnt_q != 2'd0) ? buf0_q : (rd_pend_q ? ramRdDa : 8'h00);
        acc       = out_en && out_rdy;
        last_byte = (out_idx_q == len_q - 11'd1);
        out_sop   = out_en && (out_idx_q == 11'd0);
        out_eop   = out_en && last_byte;

        // Issue a read only if the byte it returns next cycle is guaranteed a slot even if not accepted then.
        occ       = {1'b0, cnt_q} + {2'b00, rd_pend_q} - {2'b00, acc};
        ramRdEn   = (state_q == S_READ) && (occ <= 3'd1);
        rd_pend_d = ramRdEn;

        pop_buf       = acc && (cnt_q != 2'd0);
        push          = rd_pend_q && !(acc && (cnt_q == 2'd0));
        cnt_after_pop = cnt_q;
        if (pop_buf) begin
            buf0_d        = buf1_q;
            cnt_after_pop = cnt_q - 2'd1;
        end
        if (push) begin
            if (cnt_after_pop == 2'd0) buf0_d = ramRdDa;
            else                       buf1_d = ramRdDa;
        end
        cnt_d = cnt_after_pop + {1'b0, push};

        if (acc) out_idx_d = out_idx_q + 11'd1;

        case (state_q)
            S_IDLE: begin
                if (!f_empty) state_d = S_POP;
            end
            S_POP: begin
                f_rdEn  = 1'b1;
                state_d = S_LATCH;
            end
            S_LATCH: begin
                pt_d      = f_rdDa[31:24];
                ieb_d     = d_ieb;
                len_d     = d_len;
                drop_d    = d_drop;
                ptr_d     = {d_isb, 7'h00};
                rd_cnt_d  = 11'd0;
                out_idx_d = 11'd0;
                // A dropped descriptor and a block mismatch are one error each, never both.
                if (d_drop || d_bad) err_d = err_q + 16'd1;
                state_d = d_drop ? S_RELEASE : S_READ;
            end
            S_READ: begin
                if (ramRdEn) begin
                    ptr_d    = ptr_q + 12'd1;   // wraps 4095 -> 0 naturally
                    rd_cnt_d = rd_cnt_q + 11'd1;
                    if (rd_cnt_q == len_q - 11'd1) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (acc && last_byte) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                blk_d = ieb_q;
                // Counts packets actually emitted; block-mismatch packets are still streamed, so they count.
                if (!drop_q) pkt_d = pkt_q + 16'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pt_q      <= 8'h00;
            ieb_q     <= 5'd0;
            len_q     <= 11'd0;
            drop_q    <= 1'b0;
            ptr_q     <= 12'd0;
            rd_cnt_q  <= 11'd0;
            out_idx_q <= 11'd0;
            rd_pend_q <= 1'b0;
            cnt_q     <= 2'd0;
            buf0_q    <= 8'h00;
            buf1_q    <= 8'h00;
            blk_q     <= 5'd0;
            pkt_q     <= 16'd0;
            err_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            pt_q      <= pt_d;
            ieb_q     <= ieb_d;
            len_q     <= len_d;
            drop_q    <= drop_d;
            ptr_q     <= ptr_d;
            rd_cnt_q  <= rd_cnt_d;
            out_idx_q <= out_idx_d;
            rd_pend_q <= rd_pend_d;
            cnt_q     <= cnt_d;
            buf0_q    <= buf0_d;
            buf1_q    <= buf1_d;
            blk_q     <= blk_d;
            pkt_q     <= pkt_d;
            err_q     <= err_d;
        end
    end

    assign ramRdAddr  = ptr_q;
    assign ramRdBlk   = blk_q;
    assign out_pt     = pt_q;
    assign out_len    = len_q;
    assign rd_pkt_cnt = pkt_q;
    assign rd_err_cnt = err_q;

endmodule

// File: tb/tb_tfe_rxm_rd_sys.sv
// Bench for tfe_rxm_rd_sys: RAM and descriptor FIFO models, a byte-stream scoreboard built from the
// descriptor rules, and directed scenarios with hand-computed block/counter/address expectations.
module tb_tfe_rxm_rd_sys;

    logic        sysclk = 1'b0;
    logic        rst = 1'b1;
    logic        f_empty;
    logic        f_rdEn;
    logic [31:0] f_rdDa = 32'h0;
    logic [11:0] ramRdAddr;
    logic        ramRdEn;
    logic [7:0]  ramRdDa = 8'h00;
    logic [4:0]  ramRdBlk;
    logic        out_en, out_sop, out_eop;
    logic [7:0]  out_da, out_pt;
    logic [10:0] out_len;
    logic        out_rdy = 1'b1;
    logic [15:0] rd_pkt_cnt, rd_err_cnt;

    always #5 sysclk = ~sysclk;

    tfe_rxm_rd_sys #(.STRIP_FCS(1'b1)) dut (
        .sysclk(sysclk), .rst(rst),
        .f_empty(f_empty), .f_rdEn(f_rdEn), .f_rdDa(f_rdDa),
        .ramRdAddr(ramRdAddr), .ramRdEn(ramRdEn), .ramRdDa(ramRdDa), .ramRdBlk(ramRdBlk),
        .out_en(out_en), .out_da(out_da), .out_sop(out_sop), .out_eop(out_eop),
        .out_pt(out_pt), .out_len(out_len), .out_rdy(out_rdy),
        .rd_pkt_cnt(rd_pkt_cnt), .rd_err_cnt(rd_err_cnt)
    );

    // RAM and descriptor FIFO models
    logic [7:0]  mem [4096];
    logic [31:0] desc_mem [16];
    int          wr_idx = 0;
    int          rd_idx = 0;
    int          cyc = 0;
    bit          bp_mode = 1'b0;

    assign f_empty = (wr_idx == rd_idx);

    always @(posedge sysclk) begin
        cyc <= cyc + 1;
        if (ramRdEn) ramRdDa <= mem[ramRdAddr];
        if (f_rdEn && (rd_idx != wr_idx)) begin
            f_rdDa <= desc_mem[rd_idx];
            rd_idx <= rd_idx + 1;
        end
    end

    always @(posedge sysclk) begin
        #2;
        out_rdy = bp_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    typedef struct {
        logic [7:0]  da;
        logic        sop;
        logic        eop;
        logic [7:0]  pt;
        logic [10:0] len;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Per-packet observations used by the literal checks
    int          t_pop = 0;
    int          n_acc = 0;
    logic [11:0] first_addr = 12'h0;
    bit          first_pend = 1'b0;
    bit          prev_stall = 1'b0;
    logic [9:0]  prev_vec = 10'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Expected stream straight from the descriptor rules: LEN bytes from ISB*128 onward, modulo 4 KB.
    task automatic push_desc(input logic [7:0] pt, input logic [4:0] isb, input logic [4:0] ieb,
                             input logic [10:0] dl);
        logic [11:0] a;
        int          len;
        exp_t        e;
        desc_mem[wr_idx] = {pt, 3'b000, ieb, isb, dl};
        if (dl >= 11'd5) begin
            len = int'(dl) - 4;
            for (int i = 0; i < len; i++) begin
                a      = {isb, 7'h00} + 12'(i);
                e.da   = mem[a];
                e.sop  = (i == 0);
                e.eop  = (i == len - 1);
                e.pt   = pt;
                e.len  = 11'(len);
                exp_q.push_back(e);
            end
        end
        wr_idx = wr_idx + 1;
    endtask

    task automatic compare_loop();
        exp_t e;
        forever begin
            @(negedge sysclk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (f_rdEn) begin
                    check("rdEn_while_empty", {31'd0, f_empty}, 32'd0);
                    t_pop      = cyc;
                    first_pend = 1'b1;
                    n_acc      = 0;
                end
                if (ramRdEn && first_pend) begin
                    first_addr = ramRdAddr;
                    first_pend = 1'b0;
                end
                if (prev_stall) begin
                    check("hold_en", {31'd0, out_en}, 32'd1);
                    check("hold_bytes", {22'd0, out_da, out_sop, out_eop}, {22'd0, prev_vec});
                end
                if (out_en) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", {31'd0, out_en}, 32'd0);
                    end else begin
                        e = exp_q[0];
                        check("out_da", {24'd0, out_da}, {24'd0, e.da});
                        check("out_sop", {31'd0, out_sop}, {31'd0, e.sop});
                        check("out_eop", {31'd0, out_eop}, {31'd0, e.eop});
                        check("out_pt", {24'd0, out_pt}, {24'd0, e.pt});
                        check("out_len", {21'd0, out_len}, {21'd0, e.len});
                        if (out_sop && !prev_stall) check("sop_latency", cyc - t_pop, 32'd3);
                        if (out_rdy) begin
                            void'(exp_q.pop_front());
                            n_acc++;
                        end
                    end
                end
                prev_stall = out_en && !out_rdy;
                prev_vec   = {out_da, out_sop, out_eop};
            end
        end
    endtask

    task automatic wait_done();
        int k = 0;
        while ((exp_q.size() != 0 || !f_empty) && k < 4000) begin
            @(posedge sysclk);
            k++;
        end
        check("stream_drained", exp_q.size(), 32'd0);
        repeat (6) @(posedge sysclk);
        #2;
    endtask

    task automatic check_regs(input string tag, input logic [4:0] blk, input logic [15:0] pkt,
                              input logic [15:0] err);
        check({tag, "_ramRdBlk"}, {27'd0, ramRdBlk}, {27'd0, blk});
        check({tag, "_pkt_cnt"}, {16'd0, rd_pkt_cnt}, {16'd0, pkt});
        check({tag, "_err_cnt"}, {16'd0, rd_err_cnt}, {16'd0, err});
    endtask

    task automatic check_zero_outs(input string tag);
        check({tag, "_ctl"}, {2'd0, f_rdEn, ramRdEn, ramRdAddr, ramRdBlk, out_en, out_da, out_sop, out_eop},
              32'd0);
        check({tag, "_meta"}, {13'd0, out_pt, out_len}, 32'd0);
        check({tag, "_cnts"}, {rd_pkt_cnt, rd_err_cnt}, 32'd0);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        fork
            compare_loop();
        join_none

        rst = 1'b1;
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        check_zero_outs("reset");
        @(posedge sysclk);
        #2;
        rst = 1'b0;

        // 64-byte frame from block 2: 60 bytes from 0x100
        push_desc(8'h02, 5'd2, 5'd2, 11'd64);
        wait_done();
        check("t1_first_addr", {20'd0, first_addr}, 32'h100);
        check("t1_bytes", n_acc, 32'd60);
        check_regs("t1", 5'd2, 16'd1, 16'd0);

        // Frame wrapping 4095 -> 0: ISB=31, DL=300, IEB=1
        push_desc(8'h11, 5'd31, 5'd1, 11'd300);
        wait_done();
        check("t2_first_addr", {20'd0, first_addr}, 32'hF80);
        check("t2_bytes", n_acc, 32'd296);
        check_regs("t2", 5'd1, 16'd2, 16'd0);

        // 200-byte frame with random backpressure: ISB=6, DL=204, IEB=7
        bp_mode = 1'b1;
        push_desc(8'h33, 5'd6, 5'd7, 11'd204);
        wait_done();
        bp_mode = 1'b0;
        check("t3_bytes", n_acc, 32'd200);
        check_regs("t3", 5'd7, 16'd3, 16'd0);

        // Degenerate DL=3 is dropped but still releases IEB=5
        push_desc(8'h44, 5'd0, 5'd5, 11'd3);
        repeat (12) @(posedge sysclk);
        #2;
        check_regs("t4_drop", 5'd5, 16'd3, 16'd1);

        // Next descriptor is normal; DL=5 gives a single byte carrying both sop and eop
        push_desc(8'h55, 5'd10, 5'd10, 11'd5);
        wait_done();
        check("t4_bytes", n_acc, 32'd1);
        check_regs("t4_next", 5'd10, 16'd4, 16'd1);

        // Inconsistent IEB: ISB=0, DL=200 ends in block 1 but descriptor says 3
        push_desc(8'h66, 5'd0, 5'd3, 11'd200);
        wait_done();
        check("t5_bytes", n_acc, 32'd196);
        check_regs("t5", 5'd3, 16'd5, 16'd2);

        // Back-to-back A (20 bytes) and B (100 bytes); reset once 40 bytes of B are out
        push_desc(8'h77, 5'd8, 5'd8, 11'd24);
        push_desc(8'h88, 5'd12, 5'd12, 11'd104);
        k = 0;
        while (exp_q.size() > 60 && k < 2000) begin
            @(posedge sysclk);
            k++;
        end
        check("t6_reached_mid_b", {31'd0, exp_q.size() <= 60}, 32'd1);
        #2;
        check("t6_a_released", {27'd0, ramRdBlk}, 32'd8);
        check("t6_a_counted", {16'd0, rd_pkt_cnt}, 32'd6);
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        check_zero_outs("midreset");
        @(posedge sysclk);
        #2;
        rst = 1'b0;

        // Fresh descriptor after reset: ISB=20, DL=68, IEB=20
        push_desc(8'h99, 5'd20, 5'd20, 11'd68);
        wait_done();
        check("t6_first_addr", {20'd0, first_addr}, 32'hA00);
        check("t6_bytes", n_acc, 32'd64);
        check_regs("t6", 5'd20, 16'd1, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
